cam_stream_gen: RTL
===================

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 8, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 4, active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 4, href-low pclk cycles after each line's bytes.
REQ-004 SHALL have parameter VSYNC_LINES, default 1, line periods vsync is high.
REQ-005 SHALL have parameter V_BACK, default 1, blank lines between vsync fall and first active line.
REQ-006 SHALL have parameter V_FRONT, default 1, blank lines after last active line.
REQ-007 SHALL have port pclk  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-009 SHALL have port enable  input  1  request continuous frame generation.
REQ-010 SHALL have ports blobX/blobW  input  8 each  blob column start/width in pixels.
REQ-011 SHALL have ports blobY/blobH  input  8 each  blob line start/height in lines.
REQ-012 SHALL have ports fgColor/bgColor  input  16 each  RGB565 value inside/outside blob.
REQ-013 SHALL have port href  output  1  line-valid, camera convention.
REQ-014 SHALL have port vsync  output  1  frame sync, active-high.
REQ-015 SHALL have port camData  output  8  pixel byte stream.
REQ-016 SHALL have port frameDone  output  1  one-cycle pulse at end of each frame.
REQ-017 SHALL have port frameCount  output  16  completed frames, wraps 16'hFFFF->0.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL define LINE_CLKS = 2*H_ACTIVE + H_BLANK; all blanking periods are whole multiples of LINE_CLKS.
REQ-020 SHALL implement states IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT -> (VSYNC if enable else IDLE).
REQ-021 SHALL leave IDLE on the edge sampling enable=1; vsync=1 is registered on that same edge.
REQ-022 SHALL hold vsync high for exactly VSYNC_LINES*LINE_CLKS cycles, low in all other states.
REQ-023 SHALL in ACTIVE emit V_ACTIVE lines: href high 2*H_ACTIVE cycles, then low H_BLANK cycles.
REQ-024 SHALL send each pixel as two bytes: high byte [15:8] first, low byte [7:0] on next cycle.
REQ-025 SHALL select fgColor iff blobX <= x < blobX+blobW and blobY <= y < blobY+blobH (9-bit compare, no wrap), else bgColor; x,y are zero-based active pixel/line indices.
REQ-026 SHALL drive camData = 0 whenever href = 0.
REQ-027 SHALL latch blob*, fgColor, bgColor on VSYNC entry; changes mid-frame take effect next frame.
REQ-028 SHALL sample enable only at VFRONT end; deassertion mid-frame completes the current frame.
REQ-029 SHALL pulse frameDone and increment frameCount on the last VFRONT cycle.
REQ-030 SHALL register all outputs (no combinational paths from inputs to outputs).
REQ-031 SHALL treat blobW=0 or blobH=0 as empty blob (all bgColor).

Reset
REQ-032 SHALL asynchronously force state=IDLE, href=0, vsync=0, camData=0, frameDone=0, frameCount=0, busy=0, all counters 0.
REQ-033 SHALL on reset mid-frame abort immediately; after release, restart only from IDLE via enable.

Structure
REQ-034 SHALL place state encodings and default timing constants in a shared cam_defs include used by binarize benches.
REQ-035 SHALL split line/column counting into one sub-module cam_timing (byte counter, line counter, end-of-line/end-of-period strobes); pixel selection stays in top.

Verification
REQ-036 Defaults, enable held high -> vsync high 20 cycles, first href rise 40 cycles after vsync rise, frame period 140 cycles.
REQ-037 fg=16'hFFFF, bg=0, blob x=2,y=1,w=3,h=2 -> lines 1,2 bytes 4..9 = 8'hFF, all other active bytes 8'h00.
REQ-038 fg=16'hBEEF, full-frame blob -> byte sequence BE,EF repeated, 16 bytes per line, camData=0 in blanking.
REQ-039 Deassert enable mid-ACTIVE -> frame completes, frameDone pulses once, frameCount +1, busy falls, no further vsync.
REQ-040 Assert reset mid-line -> href, vsync, camData 0 asynchronously; frameCount 0; restart after enable gives full frame.
REQ-041 Loop output into binarize with threshold between fg and bg -> bin high exactly on blob pixels.

Source files
------------

// File: rtl/cam_stream_gen_pkg.sv
// Shared definitions for the camera stream generator: default timing, state
// encoding, latched blob configuration and the blob span test.
package cam_stream_gen_pkg;

    localparam int unsigned DEF_H_ACTIVE    = 8;
    localparam int unsigned DEF_V_ACTIVE    = 4;
    localparam int unsigned DEF_H_BLANK     = 4;
    localparam int unsigned DEF_VSYNC_LINES = 1;
    localparam int unsigned DEF_V_BACK      = 1;
    localparam int unsigned DEF_V_FRONT     = 1;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned COORD_W = 9;
    localparam int unsigned PIX_W   = 16;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } cam_state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] x;
        logic [BYTE_W-1:0] w;
        logic [BYTE_W-1:0] y;
        logic [BYTE_W-1:0] h;
        logic [PIX_W-1:0]  fg;
        logic [PIX_W-1:0]  bg;
    } blob_cfg_t;

    function automatic int unsigned line_clks(int unsigned h_active, int unsigned h_blank);
        return 2 * h_active + h_blank;
    endfunction

    // start <= pos < start+len evaluated one bit wider so the end never wraps
    function automatic logic in_span(logic [BYTE_W-1:0] start, logic [BYTE_W-1:0] len,
                                     logic [COORD_W-1:0] pos);
        logic [COORD_W-1:0] lo;
        logic [COORD_W-1:0] hi;
        lo = COORD_W'(start);
        hi = COORD_W'(start) + COORD_W'(len);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/cam_stream_gen_timing.sv
// Byte and line counters for the current FSM period, with end-of-line and
// end-of-period strobes plus the counter values for the next cycle.
module cam_stream_gen_timing
    import cam_stream_gen_pkg::*;
#(
    parameter int unsigned LINE_CLKS = line_clks(DEF_H_ACTIVE, DEF_H_BLANK)
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] period_lines,
    output logic             eol_c,
    output logic             eop_c,
    output logic [CNT_W-1:0] byte_nxt_c,
    output logic [CNT_W-1:0] line_nxt_c
);

    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] line_cnt;

    // Counters restart on every period boundary so each state sees line 0 byte 0 first
    always_comb begin
        eol_c      = (byte_cnt == CNT_W'(LINE_CLKS - 1));
        eop_c      = eol_c && (line_cnt == (period_lines - CNT_W'(1)));
        byte_nxt_c = byte_cnt + CNT_W'(1);
        line_nxt_c = line_cnt;
        if (clr || eol_c) begin
            byte_nxt_c = '0;
        end
        if (clr || eop_c) begin
            line_nxt_c = '0;
        end else if (eol_c) begin
            line_nxt_c = line_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            line_cnt <= '0;
        end else begin
            byte_cnt <= byte_nxt_c;
            line_cnt <= line_nxt_c;
        end
    end

endmodule

// File: rtl/cam_stream_gen.sv
// Synthetic camera source: emits vsync/href framed RGB565 byte stream with a
// rectangular foreground blob over a flat background.
module cam_stream_gen
    import cam_stream_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned H_BLANK     = DEF_H_BLANK,
    parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned V_FRONT     = DEF_V_FRONT
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  blobX,
    input  logic [7:0]  blobW,
    input  logic [7:0]  blobY,
    input  logic [7:0]  blobH,
    input  logic [15:0] fgColor,
    input  logic [15:0] bgColor,
    output logic        href,
    output logic        vsync,
    output logic [7:0]  camData,
    output logic        frameDone,
    output logic [15:0] frameCount,
    output logic        busy
);

    localparam int unsigned LINE_CLKS = line_clks(H_ACTIVE, H_BLANK);
    localparam int unsigned HREF_CLKS = 2 * H_ACTIVE;

    cam_state_t        state;
    cam_state_t        state_nxt;
    blob_cfg_t         cfg;
    logic [CNT_W-1:0]  period_lines;
    logic              eol;
    logic              eop;
    logic [CNT_W-1:0]  byte_nxt;
    logic [CNT_W-1:0]  line_nxt;
    logic              href_d;
    logic              vsync_d;
    logic              done_d;
    logic [BYTE_W-1:0] data_d;
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    logic              in_blob;
    logic [PIX_W-1:0]  color;

    cam_stream_gen_timing #(
        .LINE_CLKS (LINE_CLKS)
    ) u_timing (
        .pclk         (pclk),
        .reset        (reset),
        .clr          (state == ST_IDLE),
        .period_lines (period_lines),
        .eol_c        (eol),
        .eop_c        (eop),
        .byte_nxt_c   (byte_nxt),
        .line_nxt_c   (line_nxt)
    );

    // Length of the current state in line periods
    always_comb begin
        period_lines = CNT_W'(1);
        case (state)
            ST_VSYNC:  period_lines = CNT_W'(VSYNC_LINES);
            ST_VBACK:  period_lines = CNT_W'(V_BACK);
            ST_ACTIVE: period_lines = CNT_W'(V_ACTIVE);
            ST_VFRONT: period_lines = CNT_W'(V_FRONT);
            default:   period_lines = CNT_W'(1);
        endcase
    end

    // Pixel coordinate of the byte about to be registered onto camData
    always_comb begin
        px      = COORD_W'(byte_nxt >> 1);
        py      = COORD_W'(line_nxt);
        in_blob = in_span(cfg.x, cfg.w, px) && in_span(cfg.y, cfg.h, py);
        color   = in_blob ? cfg.fg : cfg.bg;
    end

    // Next state plus next-cycle output values, so outputs line up with the state they describe
    always_comb begin
        state_nxt = state;
        href_d    = 1'b0;
        vsync_d   = 1'b0;
        done_d    = 1'b0;
        data_d    = '0;
        case (state)
            ST_IDLE:   if (enable) state_nxt = ST_VSYNC;
            ST_VSYNC:  if (eop) state_nxt = ST_VBACK;
            ST_VBACK:  if (eop) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (eop) state_nxt = ST_VFRONT;
            ST_VFRONT: if (eop) state_nxt = enable ? ST_VSYNC : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        vsync_d = (state_nxt == ST_VSYNC);
        href_d  = (state_nxt == ST_ACTIVE) && (byte_nxt < CNT_W'(HREF_CLKS));
        if (href_d) begin
            data_d = byte_nxt[0] ? color[7:0] : color[15:8];
        end
        done_d  = (state_nxt == ST_VFRONT) &&
                  (byte_nxt == CNT_W'(LINE_CLKS - 1)) &&
                  (line_nxt == CNT_W'(V_FRONT - 1));
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Blob settings are frozen for the whole frame at vsync entry
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            cfg <= '0;
        end else if ((state_nxt == ST_VSYNC) && (state != ST_VSYNC)) begin
            cfg <= '{x: blobX, w: blobW, y: blobY, h: blobH, fg: fgColor, bg: bgColor};
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            href       <= 1'b0;
            vsync      <= 1'b0;
            camData    <= '0;
            frameDone  <= 1'b0;
            frameCount <= '0;
            busy       <= 1'b0;
        end else begin
            href      <= href_d;
            vsync     <= vsync_d;
            camData   <= data_d;
            frameDone <= done_d;
            busy      <= (state_nxt != ST_IDLE);
            if (done_d) begin
                frameCount <= frameCount + 16'd1;
            end
        end
    end

endmodule
